// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I word type and memory responder state encoding
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word array, byte-enabled synchronous write, registered read
module mem_array
    import rv32i_types::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  rv32i_word     wdata_i,
    output rv32i_word     rdata_o
);

    logic [3:0][7:0] mem_q [DEPTH_WORDS];
    rv32i_word       rdata_q;

    // Storage is deliberately left out of reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory responder; MEM_RESPONDER_ERR_EN adds mem_err
module mem_responder
    import rv32i_types::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_read,
    input  logic       mem_write,
    input  rv32i_word  mem_address,
    input  rv32i_word  mem_wdata,
    input  logic [3:0] mem_byte_enable,
    output rv32i_word  mem_rdata,
`ifdef MEM_RESPONDER_ERR_EN
    output logic       mem_err,
`endif
    output logic       mem_resp
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    mem_resp_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    idx_q, idx_d;
    rv32i_word        wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             err_q, err_d;
    logic             zero_q, zero_d;

    logic          req;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          rd_entry;
    logic          entry_err;
    logic          arr_en;
    logic          arr_we;
    logic [AW-1:0] arr_addr;
    rv32i_word     arr_rdata;
    logic          addr_unused;

    assign req         = mem_read | mem_write;
    assign acc_idx     = mem_address[AW+1:2];
    assign addr_unused = ^{mem_address[31:AW+2], mem_address[1:0]};

`ifdef MEM_RESPONDER_ERR_EN
    assign acc_err = (mem_read && mem_write)
                   || (|mem_address[31:AW+2])
                   || ((mem_byte_enable == 4'b1111) && (mem_address[1:0] != 2'b00));
`else
    assign acc_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = err_q;
        zero_d    = zero_q;
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = idx_q;
        rd_entry  = 1'b0;
        entry_err = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = mem_write;
                    idx_d   = acc_idx;
                    wdata_d = mem_wdata;
                    be_d    = mem_byte_enable;
                    err_d   = acc_err;
                    if (LATENCY == 1) begin
                        // Request fields are not latched yet, so read straight from the inputs.
                        state_d   = RESP;
                        rd_entry  = !mem_write;
                        entry_err = acc_err;
                        arr_addr  = acc_idx;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    rd_entry = !wr_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (wr_q && !err_q) begin
                    arr_en = 1'b1;
                    arr_we = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // An errored read presents zero instead of touching the array.
        if (rd_entry) begin
            zero_d = entry_err;
            arr_en = !entry_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (arr_en),
        .we_i    (arr_we),
        .be_i    (be_q),
        .addr_i  (arr_addr),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign mem_resp  = (state_q == RESP);
    assign mem_rdata = zero_q ? '0 : arr_rdata;
`ifdef MEM_RESPONDER_ERR_EN
    assign mem_err   = mem_resp & err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at LATENCY 2 and LATENCY 1
module tb_mem_responder;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [3:0]  be_s   [2];
    logic [31:0] rdata  [2];
    logic        resp   [2];
`ifdef MEM_RESPONDER_ERR_EN
    logic        err_o  [2];
`endif

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (rd_s[0]),
        .mem_write       (wr_s[0]),
        .mem_address     (addr_s[0]),
        .mem_wdata       (wd_s[0]),
        .mem_byte_enable (be_s[0]),
        .mem_rdata       (rdata[0]),
`ifdef MEM_RESPONDER_ERR_EN
        .mem_err         (err_o[0]),
`endif
        .mem_resp        (resp[0])
    );

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (rd_s[1]),
        .mem_write       (wr_s[1]),
        .mem_address     (addr_s[1]),
        .mem_wdata       (wd_s[1]),
        .mem_byte_enable (be_s[1]),
        .mem_rdata       (rdata[1]),
`ifdef MEM_RESPONDER_ERR_EN
        .mem_err         (err_o[1]),
`endif
        .mem_resp        (resp[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic check_resp(input int k);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (k == 0 && q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
        if (k == 1 && q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
        n_assert++;
        if (!have) begin
            n_fail++;
            $display("FAIL unexpected_resp dut%0d: mem_resp=1 at cycle %0d, required no response", k, cyc);
            return;
        end
        n_assert++;
        if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL resp_cycle dut%0d: got cycle %0d, required %0d", k, cyc, e.cyc);
        end
        chk($sformatf("rdata_dut%0d", k), rdata[k], e.data);
`ifdef MEM_RESPONDER_ERR_EN
        chk($sformatf("err_dut%0d", k), {31'd0, err_o[k]}, {31'd0, e.err});
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (resp[0]) check_resp(0);
            if (resp[1]) check_resp(1);
        end
    end

    task automatic push_exp(input int k, input int c, input logic [31:0] d, input bit e);
        exp_t x;
        x.cyc  = c;
        x.data = d;
        x.err  = e;
        if (k == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // hold=0 keeps the request up until n_resp pulses are seen; hold=N drops it after N edges.
    task automatic txn(input int k, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp_rd,
                       input bit exp_err, input int n_resp, input int hold);
        int c;
        int seen;
        int lat;
        lat = (k == 0) ? 2 : 1;
        @(posedge clk);
        #1;
        rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = a; wd_s[k] = d; be_s[k] = be;
        c = cyc;
        if (rd && !wr) last_rd[k] = exp_rd;
        for (int i = 0; i < n_resp; i++) push_exp(k, c + (i + 1) * lat + i, last_rd[k], exp_err);
        seen = 0;
        for (int t = 0; t < 40 && seen < n_resp; t++) begin
            @(posedge clk);
            #1;
            if (hold > 0 && t + 1 >= hold) begin rd_s[k] = 1'b0; wr_s[k] = 1'b0; end
            if (resp[k]) seen++;
        end
        rd_s[k] = 1'b0; wr_s[k] = 1'b0;
        n_assert++;
        if (seen != n_resp) begin
            n_fail++;
            $display("FAIL resp_timeout dut%0d: got %0d pulses, required %0d", k, seen, n_resp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_s[k] = 1'b0; wr_s[k] = 1'b0; addr_s[k] = '0; wd_s[k] = '0; be_s[k] = '0;
            last_rd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_resp0", {31'd0, resp[0]}, 32'd0);
        chk("reset_rdata0", rdata[0], 32'd0);
        chk("reset_resp1", {31'd0, resp[1]}, 32'd0);
        chk("reset_rdata1", rdata[1], 32'd0);

        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        0, 1, 0);
        txn(0, 1, 0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 0, 1, 0);
        txn(0, 0, 1, 32'h20, 32'h11223344, 4'b1111, 32'h0,        0, 1, 0);
        txn(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0011, 32'h0,        0, 1, 0);
        txn(0, 1, 0, 32'h20, 32'h0,        4'b0000, 32'h1122CCDD, 0, 1, 0);
        txn(0, 0, 1, 32'h22, 32'h00EE0000, 4'b0100, 32'h0,        0, 1, 0);
        txn(0, 1, 0, 32'h23, 32'h0,        4'b0000, 32'h11EECCDD, 0, 1, 0);
        txn(0, 0, 1, 32'h0,  32'hCAFEF00D, 4'b1111, 32'h0,        0, 1, 1);
        txn(0, 1, 0, 32'h0,  32'h0,        4'b0000, 32'hCAFEF00D, 0, 1, 0);
`ifdef MEM_RESPONDER_ERR_EN
        txn(0, 1, 0, 32'h400, 32'h0,        4'b0000, 32'h0,        1, 1, 0);
        txn(0, 0, 1, 32'h8,   32'h0BADF00D, 4'b1111, 32'h0,        0, 1, 0);
        txn(0, 1, 1, 32'h8,   32'hFFFFFFFF, 4'b1111, 32'h0,        1, 1, 0);
        txn(0, 1, 0, 32'h8,   32'h0,        4'b0000, 32'h0BADF00D, 0, 1, 0);
        txn(0, 1, 0, 32'h6,   32'h0,        4'b1111, 32'h0,        1, 1, 0);
`else
        txn(0, 1, 0, 32'h400, 32'h0,        4'b0000, 32'hCAFEF00D, 0, 1, 0);
        txn(0, 1, 1, 32'h8,   32'h600DCAFE, 4'b1111, 32'h0,        0, 1, 0);
        txn(0, 1, 0, 32'h8,   32'h0,        4'b0000, 32'h600DCAFE, 0, 1, 0);
`endif
        txn(0, 0, 1, 32'h30, 32'h12345678, 4'b1111, 32'h0,        0, 1, 0);
        txn(0, 1, 0, 32'h30, 32'h0,        4'b0000, 32'h12345678, 0, 1, 0);

        @(posedge clk);
        #1;
        wr_s[0] = 1'b1; addr_s[0] = 32'h30; wd_s[0] = 32'h55; be_s[0] = 4'b1111;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        wr_s[0] = 1'b0;
        #1;
        chk("midreset_rdata0", rdata[0], 32'd0);
        chk("midreset_resp0", {31'd0, resp[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        chk("post_reset_rdata0", rdata[0], 32'd0);
        txn(0, 1, 0, 32'h30, 32'h0,        4'b0000, 32'h12345678, 0, 1, 0);

        txn(1, 0, 1, 32'h4,  32'hA5A5A5A5, 4'b1111, 32'h0,        0, 1, 0);
        txn(1, 1, 0, 32'h4,  32'h0,        4'b0000, 32'hA5A5A5A5, 0, 1, 0);
        txn(1, 0, 1, 32'h4,  32'h5A5A5A5A, 4'b1001, 32'h0,        0, 1, 0);
        txn(1, 1, 0, 32'h4,  32'h0,        4'b0000, 32'h5AA5A55A, 0, 2, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("queue0_empty", q0.size(), 32'd0);
        chk("queue1_empty", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
